tri_buf32: RTL and testbench

- 32-bit tri-state bus driver for the ALU datapath.
- Puts operand A onto a shared result bus when enable C is high, and releases the bus (high-Z) when C is low.
- Data and enable are registered on the clock, so the drive/release timing is synchronous. The asynchronous active-low reset releases the bus immediately.
- A parameter selects a purely combinational mode for use inside single-cycle paths.

---
 rtl/tri_buf32.sv | 63 ++++++
 tb/tb_tri_buf32.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/tri_buf32.sv
// Tri-state bus driver: places A onto a shared result bus when C is high and
// releases the bus (all-Z) otherwise. Registered mode adds one cycle of
// latency on both drive and release; combinational mode is a plain gate.
module tri_buf32 #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic             C,
  output tri   [WIDTH-1:0] Result,
  output logic             drv_active
);

  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] data_q, data_d;
    logic             en_q, en_d;

    // Next state: data follows A; only a clean 1 on C enables the driver.
    always_comb begin
      data_d = A;
      en_d   = 1'b0;
      // An X/Z enable falls through to the disabled default.
      if (C == 1'b1) begin
        en_d = 1'b1;
      end
    end

    // Capture registers; reset releases the bus without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        en_q   <= 1'b0;
      end else begin
        data_q <= data_d;
        en_q   <= en_d;
      end
    end

    // All bits are driven or released together.
    assign Result     = en_q ? data_q : {WIDTH{1'bz}};
    assign drv_active = en_q;
  end else begin : g_comb
    logic en;

    // Enable decode; X/Z on C counts as disabled.
    always_comb begin
      en = 1'b0;
      if (C == 1'b1) begin
        en = 1'b1;
      end
    end

    assign Result     = en ? A : {WIDTH{1'bz}};
    assign drv_active = en;

    // Clock and reset play no role in this mode.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
  end

endmodule

// File: tb/tb_tri_buf32.sv
// Bench for tri_buf32: a registered and a combinational instance share the
// same A/C stimulus; each bus is compared to a behavioural model of the bus.
module tb_tri_buf32;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic        C;
  wire  [31:0] bus_r;
  wire  [31:0] bus_c;
  logic        drv_r;
  logic        drv_c;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model of the registered bus: what the bus holds after the last edge.
  logic        m_en;
  logic [31:0] m_data;

  tri_buf32 #(.WIDTH(32), .REGISTERED(1'b1)) u_dut_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (A),
    .C          (C),
    .Result     (bus_r),
    .drv_active (drv_r)
  );

  tri_buf32 #(.WIDTH(32), .REGISTERED(1'b0)) u_dut_comb (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (A),
    .C          (C),
    .Result     (bus_c),
    .drv_active (drv_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus observation: bit 32 flags an all-Z bus, low bits carry driven data.
  wire [32:0] obs_r = (bus_r === 32'hzzzzzzzz) ? {1'b1, 32'h0} : {1'b0, bus_r};
  wire [32:0] obs_c = (bus_c === 32'hzzzzzzzz) ? {1'b1, 32'h0} : {1'b0, bus_c};

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (bit32=Z)", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] exp_reg();
    return m_en ? {1'b0, m_data} : {1'b1, 32'h0};
  endfunction

  // Combinational expectation straight from the current inputs.
  function automatic logic [32:0] exp_comb();
    return (C === 1'b1) ? {1'b0, A} : {1'b1, 32'h0};
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_reg_bus"}, obs_r, exp_reg());
    check({tag, "_reg_drv"}, {32'h0, drv_r}, {32'h0, m_en});
    check({tag, "_comb_bus"}, obs_c, exp_comb());
    check({tag, "_comb_drv"}, {32'h0, drv_c}, {32'h0, (C === 1'b1)});
  endtask

  // One bus cycle, entered and left just after a falling edge.
  task automatic cycle(input logic [31:0] a, input logic c, input string tag);
    A = a;
    C = c;
    #1;
    check_all({tag, "_pre"});
    @(posedge clk);
    if (rst_n) begin
      m_data = a;
      m_en   = (c === 1'b1);
    end
    #1;
    check_all({tag, "_post"});
    @(negedge clk);
  endtask

  // Reset pulse between edges, held across one rising edge.
  task automatic reset_pulse(input string tag);
    #1;
    rst_n = 1'b0;
    m_en   = 1'b0;
    m_data = 32'h0;
    #1;
    check_all({tag, "_async"});
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    A      = 32'h0;
    C      = 1'b0;
    m_en   = 1'b0;
    m_data = 32'h0;
    #1;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Disabled: bus stays released whatever A does.
    cycle(32'h00CD00AA, 1'b0, "idle0");
    cycle(32'h00CD00AA, 1'b0, "idle1");
    cycle(32'h00CD44AA, 1'b0, "idle_newa");

    // Drive, then change data while driving.
    cycle(32'hFF00AABB, 1'b1, "drive");
    cycle(32'hFAB44567, 1'b1, "redrive");

    // Reset mid-drive, release with C=1.
    reset_pulse("rst_mid");
    cycle(32'hFAB44567, 1'b1, "post_rst");

    // Drive for one cycle, release, then an unknown enable.
    cycle(32'h12345678, 1'b1, "tog_on");
    cycle(32'h12345678, 1'b0, "tog_off");
    cycle(32'h12345678, 1'b1, "tog_on2");
    cycle(32'h12345678, 1'bx, "en_x");

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset_pulse("rnd_rst");
      end else begin
        cycle($urandom, 1'($urandom_range(0, 1)), "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
